flt_repair_alloc: RTL and testbench
===================================

Name: flt_repair_alloc

Overview:
- Sits directly downstream of the fault-detection FSM in the BIST/BISR chain.
- Collects per-PE pass/fail verdicts over a valid/ready handshake and builds a ROWS x COLS fault map.
- On end of test, scans the map and assigns faulty PEs to redundant MACs (spares) in row-major order.
- Publishes the spare-to-PE remap and a repairable / unrepairable verdict to the systolic-array mux control.

Parameters:
ROWS, 2, systolic array rows
COLS, 2, systolic array columns
NUM_SPARES, 1, number of redundant MACs available for substitution
PE_IDX_W, $clog2(ROWS*COLS) (min 1), width of a flat PE index (row*COLS+col)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a new collection pass
res_valid  in  1  verdict valid
res_ready  out  1  block accepts verdict this cycle
res_row  in  $clog2(ROWS) (min 1)  row of tested PE
res_col  in  $clog2(COLS) (min 1)  column of tested PE
res_fail  in  1  1 = PE failed
test_done  in  1  one-cycle pulse; no further verdicts this pass
fault_map  out  ROWS*COLS  bit row*COLS+col = PE faulty
fault_count  out  PE_IDX_W+1  number of distinct faulty PEs
spare_en  out  NUM_SPARES  spare k is in use
spare_pe  out  NUM_SPARES*PE_IDX_W  slice k = flat index of the PE replaced by spare k
repair_done  out  1  allocation complete; level signal
repair_ok  out  1  all faults covered; valid only when repair_done=1
idx_err  out  1  sticky; an out-of-range row/col was presented

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0.
- State IDLE:
  - res_ready=0.
  - start -> COLLECT; clears fault_map, fault_count, spare_en, spare_pe, repair_done, repair_ok and idx_err.
- State COLLECT:
  - res_ready=1.
  - Handshake fires when res_valid && res_ready.
  - res_fail=1 sets the map bit. fault_count increments only if the bit was previously 0, so duplicate reports are idempotent.
  - res_fail=0 never clears a bit.
  - row>=ROWS or col>=COLS: verdict is dropped and idx_err is set.
- Leaving COLLECT:
  - test_done -> ALLOC on the next edge.
  - A handshake in the same cycle as test_done is accepted first.
- State ALLOC:
  - res_ready=0.
  - Scan pointer walks 0..ROWS*COLS-1, one PE per cycle (ROWS*COLS cycles).
  - If the map bit is set and free spares remain, assign the next spare k (ascending): spare_en[k]=1, spare_pe[k]=pointer.
  - Faulty PEs beyond NUM_SPARES stay unassigned.
  - After the last index -> DONE.
- State DONE:
  - repair_done=1 and repair_ok=(fault_count<=NUM_SPARES).
  - Both stay static until start or rst.
- Latency: repair_done rises exactly ROWS*COLS+1 cycles after the test_done cycle.
- Signal rules:
  - start in COLLECT or ALLOC restarts the pass (same clear as IDLE->COLLECT).
  - test_done outside COLLECT is ignored.
  - rst at any time aborts to IDLE with reset values.
  - fault_count saturates at ROWS*COLS (it cannot exceed it).
- Output timing: all outputs are registered, with no combinational path from inputs to outputs except res_ready, which decodes state only.

Optional Feature:
- Macro: FLT_MAP_RETAIN_EN.
- Defined:
  - start does not clear fault_map or fault_count; faults accumulate across multiple BIST passes (for example, different pattern sets).
  - spare_en, spare_pe, repair_done, repair_ok and idx_err are still cleared, and allocation is redone over the accumulated map.
- Undefined: start clears everything as above.

Decomposition:
- Package flt_repair_pkg holds:
  - state enum (IDLE, COLLECT, ALLOC, DONE) as a 2-bit typedef
  - flat-index helper function pe_idx(row,col)
  - the PE_IDX_W computation as a localparam function
- Sub-module spare_alloc_unit holds:
  - the scan pointer
  - the next-free-spare counter
  - spare_en/spare_pe registers
  - its ports: clear, scan_en, map bit, scan_done out
- Top module keeps the handshake, fault map and state register.

Test Plan:
- 2x2, NUM_SPARES=1; start, then verdicts (0,0,pass) (0,1,fail) (1,0,pass) (1,1,pass), then test_done -> after 5 cycles: fault_map=4'b0010, fault_count=1, spare_en=1, spare_pe=1, repair_done=1, repair_ok=1.
- 2x2, NUM_SPARES=1; fails at (0,1) and (1,1) -> fault_count=2, spare_pe=1 (lowest index only), repair_ok=0.
- Duplicate fail at (1,0) sent 3 times -> fault_count=1, fault_map=4'b0100; then row=2 sent -> dropped, idx_err=1, map unchanged.
- res_valid held high with test_done pulsed in the same cycle as fail at (1,1) -> (1,1) is recorded, res_ready=0 from the next cycle, and res_valid is ignored during ALLOC.
- rst asserted mid-ALLOC (cycle 2 of 4) -> the next cycle shows all outputs 0 and state IDLE; a new start and a clean pass give a correct result.
- With FLT_MAP_RETAIN_EN: pass 1 fail (0,0), pass 2 fail (1,1) -> after pass 2 fault_map=4'b1001 and fault_count=2. Without the macro, pass 2 gives fault_map=4'b1000.

Source files
------------

// File: rtl/flt_repair_pkg.sv
// Shared types and index helpers for the fault-map collector and spare allocator.
package flt_repair_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ALLOC   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Width of an index over n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pe_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/spare_alloc_unit.sv
// Walks the fault map one PE per cycle and hands out spares in ascending order.
module spare_alloc_unit
    import flt_repair_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int NUM_SPARES = 1,
    parameter int PE_IDX_W   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           scan_en,
    input  logic                           map_bit,
    output logic [PE_IDX_W-1:0]            ptr,
    output logic                           scan_done,
    output logic [NUM_SPARES-1:0]          spare_en,
    output logic [NUM_SPARES*PE_IDX_W-1:0] spare_pe
);

    localparam int CNT_W = idx_width(NUM_SPARES + 1);
    localparam logic [PE_IDX_W-1:0] LAST_PE = PE_IDX_W'(NUM_PE - 1);

    logic [CNT_W-1:0] next_free;

    assign scan_done = scan_en && (ptr == LAST_PE);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr       <= '0;
            next_free <= '0;
            spare_en  <= '0;
            spare_pe  <= '0;
        end else if (scan_en) begin
            ptr <= scan_done ? '0 : ptr + 1'b1;
            // Faulty PEs found after the spares run out are left unassigned.
            if (map_bit && (int'(next_free) < NUM_SPARES)) begin
                for (int k = 0; k < NUM_SPARES; k++) begin
                    if (int'(next_free) == k) begin
                        spare_en[k]                        <= 1'b1;
                        spare_pe[k*PE_IDX_W +: PE_IDX_W]   <= ptr;
                    end
                end
                next_free <= next_free + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flt_repair_alloc.sv
// Builds a per-PE fault map from BIST verdicts, then allocates spares in row-major order.
// Define FLT_MAP_RETAIN_EN to keep the fault map and count across start pulses.
module flt_repair_alloc
    import flt_repair_pkg::*;
#(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int NUM_SPARES = 1,
    parameter int PE_IDX_W   = idx_width(ROWS * COLS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           res_valid,
    output logic                           res_ready,
    input  logic [idx_width(ROWS)-1:0]     res_row,
    input  logic [idx_width(COLS)-1:0]     res_col,
    input  logic                           res_fail,
    input  logic                           test_done,
    output logic [ROWS*COLS-1:0]           fault_map,
    output logic [PE_IDX_W:0]              fault_count,
    output logic [NUM_SPARES-1:0]          spare_en,
    output logic [NUM_SPARES*PE_IDX_W-1:0] spare_pe,
    output logic                           repair_done,
    output logic                           repair_ok,
    output logic                           idx_err,
    output state_t                         state
);

    localparam int NUM_PE = ROWS * COLS;

    logic [PE_IDX_W-1:0] flat_idx;
    logic [PE_IDX_W-1:0] scan_ptr;
    logic                in_range;
    logic                scan_done;

    assign in_range  = (int'(res_row) < ROWS) && (int'(res_col) < COLS);
    assign flat_idx  = PE_IDX_W'(pe_idx(int'(res_row), int'(res_col), COLS));
    assign res_ready = (state == COLLECT);

    // A verdict is accepted only in COLLECT, where res_valid && res_ready holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fault_map   <= '0;
            fault_count <= '0;
            repair_done <= 1'b0;
            repair_ok   <= 1'b0;
            idx_err     <= 1'b0;
        end else if (start) begin
            state       <= COLLECT;
            repair_done <= 1'b0;
            repair_ok   <= 1'b0;
            idx_err     <= 1'b0;
`ifdef FLT_MAP_RETAIN_EN
            // Faults accumulate over successive passes.
`else
            fault_map   <= '0;
            fault_count <= '0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (res_valid) begin
                        if (!in_range) begin
                            idx_err <= 1'b1;
                        end else if (res_fail && !fault_map[flat_idx]) begin
                            fault_map[flat_idx] <= 1'b1;
                            if (int'(fault_count) < NUM_PE) begin
                                fault_count <= fault_count + 1'b1;
                            end
                        end
                    end
                    if (test_done) begin
                        state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (scan_done) begin
                        state       <= DONE;
                        repair_done <= 1'b1;
                        repair_ok   <= (int'(fault_count) <= NUM_SPARES);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    spare_alloc_unit #(
        .NUM_PE     (NUM_PE),
        .NUM_SPARES (NUM_SPARES),
        .PE_IDX_W   (PE_IDX_W)
    ) u_alloc (
        .clk       (clk),
        .rst       (rst),
        .clear     (start),
        .scan_en   (state == ALLOC),
        .map_bit   (fault_map[scan_ptr]),
        .ptr       (scan_ptr),
        .scan_done (scan_done),
        .spare_en  (spare_en),
        .spare_pe  (spare_pe)
    );

endmodule

// File: tb/tb_flt_repair_alloc.sv
// Bench for flt_repair_alloc: a 2x2/1-spare and a 3x3/2-spare instance share stimulus
// and are compared every cycle against a map/popcount/scan model.
module tb_flt_repair_alloc;
    import flt_repair_pkg::*;

`ifdef FLT_MAP_RETAIN_EN
    localparam bit RETAIN = 1'b1;
`else
    localparam bit RETAIN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_fail = 1'b0;
    logic       test_done = 1'b0;
    logic [1:0] row_s = '0;
    logic [1:0] col_s = '0;

    logic       a_ready, a_done, a_ok, a_err;
    logic [3:0] a_map;
    logic [2:0] a_count;
    logic [0:0] a_en;
    logic [1:0] a_pe;
    state_t     a_state;

    logic       b_ready, b_done, b_ok, b_err;
    logic [8:0] b_map;
    logic [4:0] b_count;
    logic [1:0] b_en;
    logic [7:0] b_pe;
    state_t     b_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flt_repair_alloc #(.ROWS(2), .COLS(2), .NUM_SPARES(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_ready(a_ready),
        .res_row(row_s[0:0]), .res_col(col_s[0:0]), .res_fail(res_fail), .test_done(test_done),
        .fault_map(a_map), .fault_count(a_count), .spare_en(a_en), .spare_pe(a_pe),
        .repair_done(a_done), .repair_ok(a_ok), .idx_err(a_err), .state(a_state)
    );

    flt_repair_alloc #(.ROWS(3), .COLS(3), .NUM_SPARES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_ready(b_ready),
        .res_row(row_s), .res_col(col_s), .res_fail(res_fail), .test_done(test_done),
        .fault_map(b_map), .fault_count(b_count), .spare_en(b_en), .spare_pe(b_pe),
        .repair_done(b_done), .repair_ok(b_ok), .idx_err(b_err), .state(b_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nr(input int u); return (u == 0) ? 2 : 3; endfunction
    function automatic int nc(input int u); return (u == 0) ? 2 : 3; endfunction
    function automatic int ns(input int u); return (u == 0) ? 1 : 2; endfunction
    function automatic int nw(input int u); return (u == 0) ? 2 : 4; endfunction
    function automatic int row_of(input int u); return (u == 0) ? int'(row_s[0]) : int'(row_s); endfunction
    function automatic int col_of(input int u); return (u == 0) ? int'(col_s[0]) : int'(col_s); endfunction

    state_t     m_state [2];
    int         m_cnt   [2];
    logic [8:0] m_map   [2];
    logic       m_err   [2];
    bit         model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) model_live <= 1'b1;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_state[u] <= IDLE;
                m_cnt[u]   <= 0;
                m_map[u]   <= '0;
                m_err[u]   <= 1'b0;
            end else if (start) begin
                m_state[u] <= COLLECT;
                m_cnt[u]   <= 0;
                m_err[u]   <= 1'b0;
                if (!RETAIN) m_map[u] <= '0;
            end else if (m_state[u] == COLLECT) begin
                if (res_valid) begin
                    if (row_of(u) < nr(u) && col_of(u) < nc(u)) begin
                        if (res_fail) m_map[u][row_of(u) * nc(u) + col_of(u)] <= 1'b1;
                    end else begin
                        m_err[u] <= 1'b1;
                    end
                end
                if (test_done) begin
                    m_state[u] <= ALLOC;
                    m_cnt[u]   <= 0;
                end
            end else if (m_state[u] == ALLOC) begin
                if (m_cnt[u] == nr(u) * nc(u) - 1) m_state[u] <= DONE;
                m_cnt[u] <= m_cnt[u] + 1;
            end
        end
    end

    // Spares granted after the first k map entries have been examined.
    function automatic void alloc_model(input int u, input logic [8:0] map, input int k,
                                        output logic [1:0] en, output logic [7:0] pe);
        int used;
        used = 0;
        en   = '0;
        pe   = '0;
        for (int i = 0; i < k; i++) begin
            if (map[i] && used < ns(u)) begin
                en[used] = 1'b1;
                pe = pe | (8'(i) << (used * nw(u)));
                used++;
            end
        end
    endfunction

    task automatic check_unit(input int u, input string tag, input logic [8:0] map,
                              input logic [4:0] cnt, input logic [1:0] en, input logic [7:0] pe,
                              input logic ready, input logic done, input logic ok,
                              input logic err, input logic [1:0] st);
        int         k;
        int         nf;
        logic [1:0] e_en;
        logic [7:0] e_pe;
        k  = (m_state[u] == ALLOC) ? m_cnt[u] : (m_state[u] == DONE) ? nr(u) * nc(u) : 0;
        nf = $countones(m_map[u]);
        alloc_model(u, m_map[u], k, e_en, e_pe);
        check({tag, ".state"},       32'(st),    32'(m_state[u]));
        check({tag, ".res_ready"},   32'(ready), 32'(m_state[u] == COLLECT));
        check({tag, ".fault_map"},   32'(map),   32'(m_map[u]));
        check({tag, ".fault_count"}, 32'(cnt),   32'(nf));
        check({tag, ".spare_en"},    32'(en),    32'(e_en));
        check({tag, ".spare_pe"},    32'(pe),    32'(e_pe));
        check({tag, ".repair_done"}, 32'(done),  32'(m_state[u] == DONE));
        check({tag, ".repair_ok"},   32'(ok),    32'((m_state[u] == DONE) && (nf <= ns(u))));
        check({tag, ".idx_err"},     32'(err),   32'(m_err[u]));
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            check_unit(0, "a", 9'(a_map), 5'(a_count), 2'(a_en), 8'(a_pe),
                       a_ready, a_done, a_ok, a_err, a_state);
            check_unit(1, "b", b_map, b_count, b_en, b_pe,
                       b_ready, b_done, b_ok, b_err, b_state);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int r, input int c, input int f);
        res_valid = 1'b1;
        row_s     = 2'(r);
        col_s     = 2'(c);
        res_fail  = f[0];
        tick();
        res_valid = 1'b0;
    endtask

    task automatic pulse_done();
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (a_done && b_done) break;
            tick();
        end
        check("wait_done_timeout", 32'(a_done && b_done), 32'd1);
    endtask

    task automatic clean_pass();
        pulse_start();
        send(0, 0, 0);
        send(0, 1, 1);
        send(1, 0, 0);
        send(1, 1, 0);
        pulse_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        repeat (3) tick();
        rst = 1'b0;
        check("reset.state",       32'(a_state), 32'(IDLE));
        check("reset.fault_map",   32'(a_map),   32'd0);
        check("reset.repair_done", 32'(a_done),  32'd0);
        check("reset.res_ready",   32'(a_ready), 32'd0);

        // Single failure at (0,1): one spare covers it, done after five cycles.
        clean_pass();
        repeat (3) tick();
        check("t1.done_early", 32'(a_done), 32'd0);
        tick();
        check("t1.repair_done", 32'(a_done),  32'd1);
        check("t1.fault_map",   32'(a_map),   32'b0010);
        check("t1.fault_count", 32'(a_count), 32'd1);
        check("t1.spare_en",    32'(a_en),    32'd1);
        check("t1.spare_pe",    32'(a_pe),    32'd1);
        check("t1.repair_ok",   32'(a_ok),    32'd1);
        wait_done();

        // Two failures, one spare: lowest index wins, unrepairable.
        pulse_start();
        send(0, 1, 1);
        send(1, 1, 1);
        pulse_done();
        wait_done();
        check("t2.fault_count", 32'(a_count), 32'd2);
        check("t2.spare_pe",    32'(a_pe),    32'd1);
        check("t2.repair_ok",   32'(a_ok),    32'd0);
        check("t2.b_spare_pe",  32'(b_pe),    32'h41);
        check("t2.b_repair_ok", 32'(b_ok),    32'd1);

        // Duplicate reports, then an out-of-range row on the 3x3 instance.
        pulse_start();
        repeat (3) send(1, 0, 1);
        check("t3.fault_count", 32'(a_count), 32'd1);
        check("t3.fault_map",   32'(a_map),   32'b0100);
        send(3, 0, 1);
        check("t3.b_idx_err",   32'(b_err),   32'd1);
        check("t3.b_fault_map", 32'(b_map),   32'b000001000);
        check("t3.a_idx_err",   32'(a_err),   32'd0);
        pulse_done();
        wait_done();

        // Verdict accepted in the test_done cycle; valid ignored during ALLOC.
        pulse_start();
        res_valid = 1'b1; row_s = 2'd1; col_s = 2'd1; res_fail = 1'b1; test_done = 1'b1;
        tick();
        test_done = 1'b0; row_s = 2'd0; col_s = 2'd0;
        check("t4.res_ready", 32'(a_ready), 32'd0);
        check("t4.bit11",     32'(a_map[3]), 32'd1);
        repeat (3) tick();
        res_valid = 1'b0;
        check("t4.fault_map", 32'(a_map), 32'b1000);
        wait_done();

        // Reset in the middle of allocation, then a clean pass.
        clean_pass();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5.state",     32'(a_state), 32'(IDLE));
        check("t5.fault_map", 32'(a_map),   32'd0);
        check("t5.spare_en",  32'(a_en),    32'd0);
        check("t5.count",     32'(a_count), 32'd0);
        clean_pass();
        wait_done();
        check("t5.spare_pe",  32'(a_pe), 32'd1);
        check("t5.repair_ok", 32'(a_ok), 32'd1);

        // Two passes: map retention depends on FLT_MAP_RETAIN_EN.
        pulse_start();
        send(0, 0, 1);
        pulse_done();
        wait_done();
        pulse_start();
        send(1, 1, 1);
        pulse_done();
        wait_done();
        check("t6.fault_map",   32'(a_map),   RETAIN ? 32'b1001 : 32'b1000);
        check("t6.fault_count", 32'(a_count), RETAIN ? 32'd2 : 32'd1);

        // Random passes checked by the per-cycle model.
        for (int p = 0; p < 40; p++) begin
            pulse_start();
            nv = $urandom_range(0, 8);
            for (int v = 0; v < nv; v++) begin
                res_valid = ($urandom_range(0, 3) != 0);
                row_s     = 2'($urandom_range(0, 3));
                col_s     = 2'($urandom_range(0, 3));
                res_fail  = 1'($urandom_range(0, 1));
                start     = ($urandom_range(0, 15) == 0);
                tick();
                start     = 1'b0;
            end
            res_valid = 1'b0;
            pulse_done();
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 6)) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                wait_done();
                test_done = 1'b1;
                res_valid = 1'b1;
                res_fail  = 1'b1;
                tick();
                test_done = 1'b0;
                res_valid = 1'b0;
            end
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
